// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces presses and releases,
// and hands accepted key codes to the consumer through a valid/ack handshake.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       key_drop
);
    localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_ACCEPT,
        ST_HELD
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       row_meta, rs;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             any_low;
    logic             row_low;
    logic [1:0]       row_pick;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [CNT_W-1:0] rel_cnt, rel_cnt_nxt;
    logic [3:0]       col_nxt;
    logic [3:0]       key_code_nxt;
    logic             key_valid_nxt;
    logic             key_held_nxt;
    logic             key_drop_nxt;

    assign tick    = (div_cnt == DIV_LAST);
    assign any_low = ~&rs;
    assign row_low = ~rs[row_idx];

    // Lowest-index low row wins when several rows are pulled down.
    always_comb begin
        casez (rs)
            4'b???0: row_pick = 2'd0;
            4'b??01: row_pick = 2'd1;
            4'b?011: row_pick = 2'd2;
            default: row_pick = 2'd3;
        endcase
    end

    // Row synchronizer and free-running dwell divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
            div_cnt  <= '0;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SCAN: begin
                if (tick && any_low) begin
                    state_nxt = (DEBOUNCE_TICKS == 1) ? ST_ACCEPT : ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!row_low) begin
                        state_nxt = ST_SCAN;
                    end else if ((deb_cnt + CNT_ONE) == DEB_LAST) begin
                        state_nxt = ST_ACCEPT;
                    end
                end
            end
            ST_ACCEPT: state_nxt = ST_HELD;
            ST_HELD: begin
                if (tick && !row_low && ((rel_cnt + CNT_ONE) == DEB_LAST)) begin
                    state_nxt = ST_SCAN;
                end
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

    // Datapath and output next values; ack clears valid unless ACCEPT reloads it.
    always_comb begin
        col_idx_nxt   = col_idx;
        row_idx_nxt   = row_idx;
        deb_cnt_nxt   = deb_cnt;
        rel_cnt_nxt   = rel_cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = key_valid & ~key_ack;
        key_held_nxt  = key_held;
        key_drop_nxt  = 1'b0;
        case (state)
            ST_SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        row_idx_nxt = row_pick;
                        deb_cnt_nxt = CNT_ONE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (row_low) begin
                        deb_cnt_nxt = deb_cnt + CNT_ONE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end
            ST_ACCEPT: begin
                key_valid_nxt = 1'b1;
                key_held_nxt  = 1'b1;
                rel_cnt_nxt   = '0;
                if (!key_valid || key_ack) begin
                    key_code_nxt = {row_idx, col_idx};
                end else begin
                    key_drop_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (tick) begin
                    if (row_low) begin
                        rel_cnt_nxt = '0;
                    end else if ((rel_cnt + CNT_ONE) == DEB_LAST) begin
                        rel_cnt_nxt  = '0;
                        key_held_nxt = 1'b0;
                        col_idx_nxt  = col_idx + 2'd1;
                    end else begin
                        rel_cnt_nxt = rel_cnt + CNT_ONE;
                    end
                end
            end
            default: ;
        endcase
        col_nxt = ~(4'b0001 << col_idx_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            col       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            col_idx   <= col_idx_nxt;
            row_idx   <= row_idx_nxt;
            deb_cnt   <= deb_cnt_nxt;
            rel_cnt   <= rel_cnt_nxt;
            col       <= col_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            key_drop  <= key_drop_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated keypad matrix, directed scenarios with literal
// expectations, and randomized presses/acks checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       key_drop;

    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_row;
    logic [3:0]  kp_row;
    logic        chk_en = 1'b0;
    int          cyc_cnt;
    int          errors = 0;
    int          checks = 0;
    int          fail_prints = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .key_drop(key_drop)
    );

    always #5 clk = ~clk;

    // Matrix physics: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) kp_row[r] = 1'b0;
    end
    assign row = force_en ? force_row : kp_row;

    always @(posedge clk or posedge rst)
        if (rst) cyc_cnt <= 0;
        else     cyc_cnt <= cyc_cnt + 1;

    // Behavioural model: phase 0 scanning, 1 confirming press, 2 accepting, 3 awaiting release.
    int         m_phase, m_div, m_col, m_row, m_deb, m_rel;
    logic [3:0] m_s1, m_rs, m_code;
    logic       m_valid, m_held, m_drop;

    task automatic model_reset();
        m_phase = 0; m_div = 0; m_col = 0; m_row = 0; m_deb = 0; m_rel = 0;
        m_s1 = 4'hF; m_rs = 4'hF; m_code = 4'h0;
        m_valid = 1'b0; m_held = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step();
        bit tk;
        int low_row;
        tk = (m_div == SCAN_DIV - 1);
        m_div = (m_div + 1) % SCAN_DIV;
        low_row = -1;
        for (int r = 3; r >= 0; r--) if (!m_rs[r]) low_row = r;
        m_drop = 1'b0;
        if (m_valid && key_ack && m_phase != 2) m_valid = 1'b0;
        case (m_phase)
            0: if (tk) begin
                if (low_row >= 0) begin
                    m_row = low_row; m_deb = 1;
                    m_phase = (m_deb >= DEB) ? 2 : 1;
                end else m_col = (m_col + 1) % 4;
            end
            1: if (tk) begin
                if (!m_rs[m_row]) begin
                    m_deb++;
                    if (m_deb >= DEB) m_phase = 2;
                end else begin
                    m_phase = 0; m_col = (m_col + 1) % 4;
                end
            end
            2: begin
                if (!m_valid || key_ack) begin
                    m_code = 4'(m_row * 4 + m_col); m_valid = 1'b1;
                end else m_drop = 1'b1;
                m_held = 1'b1; m_rel = 0; m_phase = 3;
            end
            default: if (tk) begin
                if (m_rs[m_row]) begin
                    m_rel++;
                    if (m_rel >= DEB) begin
                        m_held = 1'b0; m_phase = 0; m_col = (m_col + 1) % 4;
                    end
                end else m_rel = 0;
            end
        endcase
        m_rs = m_s1;
        m_s1 = row;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    function automatic logic [3:0] mcol(input int i);
        logic [3:0] one;
        logic [1:0] sh;
        one = 4'b0001;
        sh  = i[1:0];
        return ~(one << sh);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
            fail_prints++;
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            check("model_col",   32'(col),       32'(mcol(m_col)));
            check("model_code",  32'(key_code),  32'(m_code));
            check("model_valid", 32'(key_valid), 32'(m_valid));
            check("model_held",  32'(key_held),  32'(m_held));
            check("model_drop",  32'(key_drop),  32'(m_drop));
        end
    end

    // sel: 0 = key_valid high, 1 = key_held low, 2 = key_drop high.
    task automatic wait_for(input int sel, input int budget, input string name);
        int  n;
        bit  hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = key_valid;
                1:       hit = !key_held;
                default: hit = key_drop;
            endcase
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic align_tick();
        int n;
        n = 0;
        while ((cyc_cnt % SCAN_DIV) != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            @(negedge clk);
            key_ack = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        logic [3:0] step_col;
        logic [3:0] bounce_col;
        int         n;
        rst = 1'b1; key_ack = 1'b0; pressed = '0; force_en = 1'b0; force_row = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        check("reset_col",   32'(col),       32'h0000_000E);
        check("reset_valid", 32'(key_valid), 32'd0);
        check("reset_held",  32'(key_held),  32'd0);
        check("reset_code",  32'(key_code),  32'd0);
        step_col = 4'b1110;
        for (int s = 0; s < 4; s++) begin
            repeat (4) @(negedge clk);
            step_col = {step_col[2:0], step_col[3]};
            check("scan_step", 32'(col), 32'(step_col));
        end
        check("idle_valid", 32'(key_valid), 32'd0);

        // Row1/col2 press: detected at tick 28, accepted at tick 36, valid after edge 37.
        pressed[6] = 1'b1;
        wait_for(0, 100, "press_valid");
        check("press_latency", 32'(cyc_cnt), 32'd37);
        check("press_code", 32'(key_code), 32'h6);
        check("press_held", 32'(key_held), 32'd1);
        check("press_col_frozen", 32'(col), 32'hB);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("ack_clears", 32'(key_valid), 32'd0);
        check("ack_code_kept", 32'(key_code), 32'h6);
        pressed[6] = 1'b0;
        wait_for(1, 100, "release_held");
        check("release_latency", 32'(cyc_cnt), 32'd52);
        check("release_col", 32'(col), 32'h7);

        // One-tick bounce on row0.
        align_tick();
        bounce_col = col;
        force_row = 4'b1110; force_en = 1'b1;
        repeat (4) @(negedge clk);
        check("bounce_freeze", 32'(col), 32'(bounce_col));
        force_en = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce_advance", 32'(col), 32'({bounce_col[2:0], bounce_col[3]}));
        check("bounce_no_valid", 32'(key_valid), 32'd0);

        // Second press while the first is still unacknowledged.
        pressed[6] = 1'b1;
        wait_for(0, 200, "first_valid");
        check("first_code", 32'(key_code), 32'h6);
        pressed[6] = 1'b0;
        wait_for(1, 200, "first_release");
        pressed[0] = 1'b1;
        wait_for(2, 200, "drop_pulse");
        check("drop_code_kept", 32'(key_code), 32'h6);
        check("drop_valid_kept", 32'(key_valid), 32'd1);
        @(negedge clk);
        check("drop_one_cycle", 32'(key_drop), 32'd0);
        pressed[0] = 1'b0;
        wait_for(1, 200, "drop_release");

        // Ack landing in the ACCEPT cycle reloads the code and keeps valid high.
        pressed[0] = 1'b1;
        n = 0;
        while (m_phase != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_reached", 32'(m_phase == 2), 32'd1);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("ack_accept_valid", 32'(key_valid), 32'd1);
        check("ack_accept_code", 32'(key_code), 32'h0);
        check("ack_accept_nodrop", 32'(key_drop), 32'd0);
        pressed[0] = 1'b0;
        wait_for(1, 200, "accept_release");
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;

        // Rows 0 and 2 both low on column 3.
        pressed[3] = 1'b1; pressed[11] = 1'b1;
        wait_for(0, 200, "multi_valid");
        check("multi_code", 32'(key_code), 32'h3);
        check("multi_held", 32'(key_held), 32'd1);

        // Asynchronous reset while held.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_col",   32'(col),       32'hE);
        check("arst_valid", 32'(key_valid), 32'd0);
        check("arst_held",  32'(key_held),  32'd0);
        check("arst_code",  32'(key_code),  32'd0);
        check("arst_drop",  32'(key_drop),  32'd0);
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("resume_scan", 32'(col), 32'hD);

        // Randomized presses, chords, glitches and acks.
        for (int it = 0; it < 70; it++) begin
            pressed = '0;
            pressed[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
            run_random($urandom_range(1, 70));
            pressed = '0;
            run_random($urandom_range(1, 50));
            if (it == 35) begin
                @(posedge clk);
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        key_ack = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and delivers debounced key codes to game logic through a valid/ack handshake. It is the input-side counterpart of the multiplexed seven-segment output path. Like that path, it drives one active-low select line at a time, but here it reads the returned row lines instead of driving segments. It sits between the board's keypad header and the move-entry logic.

## Interface
- SCAN_DIV, 50000: clock cycles per column dwell; minimum 4.
- DEBOUNCE_TICKS, 4: number of consecutive matching ticks required to accept a press or a release; range 1..15.
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- row  input  4  keypad row returns, active-low, externally pulled up; asynchronous to clk.
- col  output  4  column drive, active-low one-hot: 4'b1110 drives column 0, and so on up to 4'b0111 for column 3.
- key_code  output  4  accepted key, encoded as {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  high while key_code holds an unacknowledged key.
- key_ack  input  1  consumer acknowledge, sampled only while key_valid=1.
- key_held  output  1  high while the accepted key is still physically pressed.
- key_drop  output  1  one-cycle pulse when a press is accepted while key_valid=1; that press is discarded.

## Operation
- row passes through a 2-flop synchronizer; all decisions use the synchronized value (rs).
- Tick: the divider counts 0..SCAN_DIV-1, and tick=1 in the cycle the count equals SCAN_DIV-1. The divider runs continuously in every state.
- col = ~(4'b0001 << col_idx). col_idx advances mod 4 only on a tick in SCAN, and when leaving DEBOUNCE or HELD back to SCAN.
- Row select: when more than one rs bit is low, the lowest-index low row wins (row_idx).
- SCAN:
  - On a tick with any rs bit low: capture row_idx, freeze col_idx, set deb_cnt=1, go to DEBOUNCE.
  - Otherwise, on a tick: advance col_idx.
- DEBOUNCE:
  - On each tick where the captured row bit is still low: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_TICKS: go to ACCEPT.
  - On a tick where the captured row bit is high: go to SCAN and advance col_idx.
  - With DEBOUNCE_TICKS=1, go to ACCEPT directly from SCAN.
- ACCEPT (one cycle):
  - If key_valid=0, or key_ack=1 in this same cycle: load key_code and set key_valid=1.
  - Otherwise: pulse key_drop and leave key_code unchanged.
  - In both cases set key_held=1 and go to HELD with rel_cnt=0.
- HELD:
  - col stays frozen.
  - Each tick with the captured row bit high: rel_cnt++. Each tick with it low: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_TICKS: key_held=0, go to SCAN, advance col_idx.
  - A held key never re-emits; there is no auto-repeat.
- Handshake:
  - key_valid=1 with key_ack=1 clears key_valid at the next edge, except when ACCEPT reloads it in the same cycle, in which case key_valid stays 1 with the new code.
  - key_ack while key_valid=0 is ignored.
  - key_code holds its value after being acknowledged.

## Timing
- Reset values: col=4'b1110, col_idx=0, key_code=4'h0, key_valid=0, key_held=0, key_drop=0, state=SCAN, divider=0, deb_cnt=0, rel_cnt=0. rst asserted mid-scan or mid-debounce aborts immediately and discards any pending key.
- Synchronizer latency is 2 cycles from a pin change to rs.
- key_valid and key_held rise at the edge ending the ACCEPT cycle, which is 1 cycle after the accepting tick.
- Minimum press-to-valid: (DEBOUNCE_TICKS-1)·SCAN_DIV + 2 cycles after the first tick that sees rs low.
- key_drop is high for exactly 1 cycle per dropped press.
- Outputs are registered; there are no combinational paths from row or key_ack to any output.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3.
- Reset, no keys pressed:
  - col steps 1110→1101→1011→0111→1110, 4 cycles per step.
  - key_valid stays 0.
- Press row1/col2 (drive row=4'b1101 while col=4'b1011) and hold:
  - col freezes at 1011.
  - key_code=4'h6 and key_valid=1, 2 ticks + 1 cycle after detection.
  - key_held=1.
  - Ack for one cycle: key_valid=0 at the next edge.
  - Release: after 3 high ticks, key_held=0 and col advances to 0111.
- Bounce: row low for 1 tick, high on the next:
  - Returns to SCAN with no key_valid.
  - col advances from the frozen column.
- Second press while the first is unacknowledged (first 4'h6, second row0/col0):
  - key_drop pulses 1 cycle.
  - key_code stays 4'h6.
- Second press with key_ack in the ACCEPT cycle:
  - key_valid stays 1 and key_code=4'h0.
- Rows 0 and 2 both low on col 3:
  - key_code=4'h3.
- rst pulsed while in HELD:
  - All outputs return to reset values asynchronously.
  - Scanning resumes from col 0.
